// File: rtl/mips_dmem_arbiter.sv
// Round-robin arbiter and access sequencer sharing the data memory port between
// the CPU load/store path (port 0) and a loader/debug port (port 1).
module mips_dmem_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int MEM_BYTES   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] mem_address,
    output logic [31:0] write_data,
    output logic        sig_mem_read,
    output logic        sig_mem_write,
    input  logic [31:0] read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

    state_t      state, state_nxt;
    logic        last_grant;
    logic        sel;
    logic        lat_we;
    logic        lat_bad;
    logic [3:0]  cnt;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] rdata0;
    logic [31:0] rdata1;

    logic        any_req;
    logic        win;
    logic [31:0] win_addr;
    logic        win_bad;

    // On a tie the port that did not win last time is served.
    assign any_req  = m0_req | m1_req;
    assign win      = (m0_req && m1_req) ? ~last_grant : m1_req;
    assign win_addr = win ? m1_addr : m0_addr;
    assign win_bad  = (win_addr[1:0] != 2'b00) || (win_addr > MAX_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = win_bad ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            sel        <= 1'b0;
            lat_we     <= 1'b0;
            lat_bad    <= 1'b0;
            cnt        <= 4'd0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            rdata0     <= 32'd0;
            rdata1     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sel       <= win;
                        lat_we    <= win ? m1_we : m0_we;
                        lat_addr  <= win_addr;
                        lat_wdata <= win ? m1_wdata : m0_wdata;
                        lat_bad   <= win_bad;
                        cnt       <= win_bad ? 4'd0 : 4'(WAIT_CYCLES);
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!lat_we) begin
                            if (sel) begin
                                rdata1 <= read_data;
                            end else begin
                                rdata0 <= read_data;
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    last_grant <= sel;
                end
                default: begin
                    last_grant <= last_grant;
                end
            endcase
        end
    end

    always_comb begin
        sig_mem_read  = 1'b0;
        sig_mem_write = 1'b0;
        m0_ack        = 1'b0;
        m1_ack        = 1'b0;
        m0_err        = 1'b0;
        m1_err        = 1'b0;
        case (state)
            ACCESS: begin
                sig_mem_write = lat_we;
                sig_mem_read  = ~lat_we;
            end
            DONE: begin
                if (sel) begin
                    m1_ack = 1'b1;
                    m1_err = lat_bad;
                end else begin
                    m0_ack = 1'b1;
                    m0_err = lat_bad;
                end
            end
            default: begin
                sig_mem_read = 1'b0;
            end
        endcase
    end

    assign mem_address = lat_addr;
    assign write_data  = lat_wdata;
    assign m0_rdata    = rdata0;
    assign m1_rdata    = rdata1;

endmodule
